// File: rtl/cpu_pkg.sv
// Shared CPU definitions: cp0 cause codes, register indices, status field
// positions and the exception sequencer state encoding.
package cpu_pkg;

  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;
  localparam logic [4:0] CAUSE_INT     = 5'b00000;

  localparam int CP0_STATUS = 12;
  localparam int CP0_CAUSE  = 13;
  localparam int CP0_EPC    = 14;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_IM_LSB = 8;

  // Wide enough for up to 8 interrupt lines.
  localparam int IRQ_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } exc_state_e;

  // Same-cycle trap priority: syscall over break over teq.
  function automatic logic [4:0] trap_cause(input logic sys, input logic brk, input logic teq);
    logic [4:0] c;
    c = CAUSE_TEQ;
    if (brk) c = CAUSE_BREAK;
    if (sys) c = CAUSE_SYSCALL;
    if (!sys && !brk && !teq) c = CAUSE_INT;
    return c;
  endfunction

endpackage

// File: rtl/exc_ctrl_irq_pending.sv
// Rising-edge capture of external interrupt lines into pending bits, with a
// lowest-index priority pick over the lines the caller marks as eligible.
module irq_pending
  import cpu_pkg::*;
#(
  parameter int NIRQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIRQ-1:0]      irq,
  input  logic [NIRQ-1:0]      ack,
  input  logic [NIRQ-1:0]      mask,
  output logic                 valid,
  output logic [IRQ_IDX_W-1:0] idx
);

  logic [NIRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] eligible;

  // valid/idx offer the lowest eligible pending line; the line is consumed
  // by pulsing ack[idx], and a new edge in that same cycle re-arms it.
  always_comb begin
    irq_prev_d = irq;
    pending_d  = (pending_q & ~ack) | (irq & ~irq_prev_q);
    eligible   = pending_q & mask;
    valid      = 1'b0;
    idx        = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        idx   = i[IRQ_IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between the decoder, the IRQ lines and cp0.
// Guarantees cp0's single saved-status slot is used by one handler at a time.
module exc_ctrl
  import cpu_pkg::*;
#(
  parameter int NIRQ   = 4,
  parameter int IM_LSB = STATUS_IM_LSB
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sys_req,
  input  logic            brk_req,
  input  logic            teq_req,
  input  logic            eret_req,
  input  logic [NIRQ-1:0] irq,
  input  logic [31:0]     status,
  output logic            exception,
  output logic            eret,
  output logic [4:0]      cause,
  output logic            stall,
  output logic [NIRQ-1:0] irq_ack,
  output logic            in_handler,
  output logic            double_fault
);

  exc_state_e state_q, state_d;
  logic            exception_q, exception_d;
  logic            eret_q, eret_d;
  logic [4:0]      cause_q, cause_d;
  logic            stall_q, stall_d;
  logic [NIRQ-1:0] irq_ack_q, irq_ack_d;
  logic            in_handler_q, in_handler_d;
  logic            double_fault_q, double_fault_d;

  logic                 trap;
  logic                 irq_valid;
  logic [IRQ_IDX_W-1:0] irq_idx;
  logic [NIRQ-1:0]      irq_mask;
  logic                 unused_status;

  assign trap          = sys_req | brk_req | teq_req;
  assign irq_mask      = status[IM_LSB +: NIRQ] & {NIRQ{status[STATUS_IE]}};
  assign unused_status = ^status;

  irq_pending #(.NIRQ(NIRQ)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .irq   (irq),
    .ack   (irq_ack_q),
    .mask  (irq_mask),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  always_comb begin
    state_d        = state_q;
    exception_d    = 1'b0;
    eret_d         = 1'b0;
    stall_d        = 1'b0;
    irq_ack_d      = '0;
    cause_d        = cause_q;
    in_handler_d   = in_handler_q;
    double_fault_d = double_fault_q;
    case (state_q)
      ST_IDLE: begin
        in_handler_d = 1'b0;
        if (trap) begin
          state_d     = ST_TAKE;
          exception_d = 1'b1;
          stall_d     = 1'b1;
          cause_d     = trap_cause(sys_req, brk_req, teq_req);
        end else if (irq_valid) begin
          state_d     = ST_TAKE;
          exception_d = 1'b1;
          stall_d     = 1'b1;
          cause_d     = CAUSE_INT;
          irq_ack_d   = NIRQ'(1) << irq_idx;
        end
      end
      ST_TAKE: begin
        state_d      = ST_HANDLER;
        in_handler_d = 1'b1;
      end
      ST_HANDLER: begin
        in_handler_d = 1'b1;
        // A nested trap would clobber the saved status: flag it, don't take it.
        if (trap) begin
          double_fault_d = 1'b1;
        end else if (eret_req) begin
          state_d = ST_RETURN;
          eret_d  = 1'b1;
          stall_d = 1'b1;
        end
      end
      ST_RETURN: begin
        state_d      = ST_IDLE;
        in_handler_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      exception_q    <= 1'b0;
      eret_q         <= 1'b0;
      cause_q        <= '0;
      stall_q        <= 1'b0;
      irq_ack_q      <= '0;
      in_handler_q   <= 1'b0;
      double_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      exception_q    <= exception_d;
      eret_q         <= eret_d;
      cause_q        <= cause_d;
      stall_q        <= stall_d;
      irq_ack_q      <= irq_ack_d;
      in_handler_q   <= in_handler_d;
      double_fault_q <= double_fault_d;
    end
  end

  assign exception    = exception_q;
  assign eret         = eret_q;
  assign cause        = cause_q;
  assign stall        = stall_q;
  assign irq_ack      = irq_ack_q;
  assign in_handler   = in_handler_q;
  assign double_fault = double_fault_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the trap/interrupt rules.
module tb_exc_ctrl;

  localparam int NIRQ   = 4;
  localparam int IM_LSB = 8;
  localparam int W      = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sys_req = 1'b0, brk_req = 1'b0, teq_req = 1'b0, eret_req = 1'b0;
  logic [NIRQ-1:0] irq = '0;
  logic [31:0]     status = '0;
  logic            exception, eret, stall, in_handler, double_fault;
  logic [4:0]      cause;
  logic [NIRQ-1:0] irq_ack;
  logic [W-1:0]    obs_vec;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  // reference model variables
  bit              m_take, m_ret, m_body, m_df;
  logic [4:0]      m_cause;
  logic [NIRQ-1:0] m_ack, m_pend, m_prev;

  exc_ctrl #(.NIRQ(NIRQ), .IM_LSB(IM_LSB)) dut (
    .clk          (clk),
    .rst          (rst),
    .sys_req      (sys_req),
    .brk_req      (brk_req),
    .teq_req      (teq_req),
    .eret_req     (eret_req),
    .irq          (irq),
    .status       (status),
    .exception    (exception),
    .eret         (eret),
    .cause        (cause),
    .stall        (stall),
    .irq_ack      (irq_ack),
    .in_handler   (in_handler),
    .double_fault (double_fault)
  );

  assign obs_vec = {exception, eret, cause, stall, irq_ack, in_handler, double_fault};

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_take = 0; m_ret = 0; m_body = 0; m_df = 0;
    m_cause = '0; m_ack = '0; m_pend = '0; m_prev = '0;
    exp_q.delete();
  endtask

  // One clock edge of the trap/interrupt rules, using the inputs seen at it.
  task automatic model_step();
    logic [NIRQ-1:0] elig;
    int lo;
    bit trap, was_take, was_ret, was_body;
    trap = sys_req | brk_req | teq_req;
    elig = m_pend & status[IM_LSB +: NIRQ] & {NIRQ{status[0]}};
    lo = -1;
    for (int i = 0; i < NIRQ; i++) if (elig[i] && lo < 0) lo = i;
    m_pend = (m_pend & ~m_ack) | (irq & ~m_prev);
    m_prev = irq;
    was_take = m_take; was_ret = m_ret; was_body = m_body;
    m_take = 0; m_ret = 0; m_ack = '0;
    if (was_take) begin
      m_body = 1;
    end else if (was_body) begin
      if (trap) m_df = 1;
      else if (eret_req) begin m_body = 0; m_ret = 1; end
    end else if (!was_ret) begin
      if (trap) begin
        m_take = 1;
        m_cause = sys_req ? 5'b01000 : brk_req ? 5'b01001 : 5'b01101;
      end else if (lo >= 0) begin
        m_take = 1;
        m_cause = 5'b00000;
        m_ack[lo] = 1'b1;
      end
    end
    exp_q.push_back({m_take, m_ret, m_cause, m_take | m_ret, m_ack, m_body | m_ret, m_df});
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic b, input logic t, input logic e,
                       input logic [NIRQ-1:0] i, input logic [31:0] st);
    sys_req = s; brk_req = b; teq_req = t; eret_req = e; irq = i; status = st;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle_outputs", obs_vec, exp_q.pop_front());
  endtask

  task automatic apply_reset();
    #3 rst = 1'b1;
    #1 check("async_reset_outputs", obs_vec, '0);
    drive(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    drive(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    check("reset_held", obs_vec, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("reset_release", obs_vec, '0);

    // sys+teq with irq[1] edge: syscall wins, interrupt waits for eret
    drive(1, 0, 1, 0, 4'b0010, 32'h0000_0201);
    cycle();
    check("sys_exception", exception, 1);
    check("sys_cause", cause, 5'b01000);
    check("sys_stall", stall, 1);
    check("sys_no_ack", irq_ack, 0);
    drive(0, 0, 0, 0, 4'b0010, 32'h0000_0201);
    cycle();
    check("handler_active", in_handler, 1);
    drive(0, 0, 0, 1, 4'b0010, 32'h0000_0201);
    cycle();
    check("ret_eret", eret, 1);
    check("ret_stall", stall, 1);
    drive(0, 0, 0, 0, 4'b0010, 32'h0000_0201);
    cycle();
    check("idle_gap", exception, 0);
    cycle();
    check("int1_exception", exception, 1);
    check("int1_cause", cause, 5'b00000);
    check("int1_ack", irq_ack, 4'b0010);

    // two simultaneous edges: lowest line first, other after eret
    apply_reset();
    drive(0, 0, 0, 0, 4'b0101, 32'h0000_0501);
    cycle();
    cycle();
    check("int0_ack", irq_ack, 4'b0001);
    cycle();
    drive(0, 0, 0, 1, 4'b0101, 32'h0000_0501);
    cycle();
    drive(0, 0, 0, 0, 4'b0101, 32'h0000_0501);
    cycle();
    cycle();
    check("int2_ack", irq_ack, 4'b0100);
    check("int2_exception", exception, 1);

    // globally disabled interrupt held pending until IE set
    apply_reset();
    drive(0, 0, 0, 0, 4'b1000, 32'h0000_0800);
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("masked_quiet", exception, 0);
    end
    drive(0, 0, 0, 0, 4'b1000, 32'h0000_0801);
    cycle();
    check("unmask_exception", exception, 1);
    check("int3_ack", irq_ack, 4'b1000);

    // break inside handler: flagged, not taken, sticky across eret
    drive(0, 0, 0, 0, 4'b1000, 32'h0000_0801);
    cycle();
    drive(0, 1, 0, 0, 4'b1000, 32'h0000_0801);
    cycle();
    check("nested_no_exception", exception, 0);
    check("double_fault_set", double_fault, 1);
    drive(0, 0, 0, 1, 4'b1000, 32'h0000_0801);
    cycle();
    drive(0, 0, 0, 0, 4'b1000, 32'h0000_0801);
    repeat (3) cycle();
    check("double_fault_sticky", double_fault, 1);

    // reset mid-handler, then prove FSM is back in IDLE
    drive(1, 0, 0, 0, 4'b1000, 32'h0000_0801);
    cycle();
    drive(0, 0, 0, 0, 4'b1000, 32'h0000_0801);
    cycle();
    check("pre_reset_handler", in_handler, 1);
    apply_reset();
    check("post_reset_df", double_fault, 0);
    drive(0, 1, 0, 0, '0, 32'h0000_0001);
    cycle();
    check("post_reset_take", cause, 5'b01001);

    // random traffic against the model
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [NIRQ-1:0] flip;
      logic s, b, t, e;
      logic [31:0] st;
      for (int i = 0; i < NIRQ; i++) flip[i] = ($urandom_range(0, 4) == 0);
      s = ($urandom_range(0, 19) == 0);
      b = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 19) == 0);
      e = !(s | b | t) && ($urandom_range(0, 2) == 0);
      st = $urandom;
      st[0] = ($urandom_range(0, 4) != 0);
      drive(s, b, t, e, irq ^ flip, st);
      cycle();
      if ($urandom_range(0, 599) == 0) apply_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
